regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 23 ++
 rtl/wb_queue.sv | 57 +++++
 rtl/regfile_write_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_DATA_W / REG_ADDR_W : register width and address width
//   REG_COUNT               : number of architectural registers
//   WB_NUM_REQ              : writeback requesters sharing the write port
//   wb_req_t                : one queued write (destination + data)
//   regOneHot               : destination address -> one-hot register mask
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int WB_NUM_REQ = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [REG_COUNT-1:0] regOneHot(input logic [REG_ADDR_W-1:0] a);
    return REG_COUNT'(1) << a;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Two-entry writeback FIFO, one per requester.
//   clock, rst   : clock, asynchronous active-high reset
//   push         : store pushEntry at the tail (caller guarantees count < 2)
//   pop          : drop the head (caller guarantees count > 0)
//   count        : occupancy 0..2
//   headEntry    : oldest entry
//   entryValid   : per-slot valid, indexed by physical slot
//   entryAddr    : per-slot destination, indexed by physical slot
module wb_queue
  import regfile_pkg::*;
(
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push,
  input  wb_req_t                    pushEntry,
  input  logic                       pop,
  output logic [1:0]                 count,
  output wb_req_t                    headEntry,
  output logic [1:0]                 entryValid,
  output logic [1:0][REG_ADDR_W-1:0] entryAddr
);

  wb_req_t mem [2];
  logic    wrPtr;
  logic    rdPtr;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign headEntry    = mem[rdPtr];
  assign entryAddr[0] = mem[0].addr;
  assign entryAddr[1] = mem[1].addr;

  // With two slots, the head slot is valid when non-empty and both are valid when full.
  always_comb begin
    entryValid = 2'b00;
    if (count != 2'd0) entryValid[rdPtr] = 1'b1;
    if (count == 2'd2) entryValid = 2'b11;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two writeback requesters.
//   clock, rst                     : clock, asynchronous active-high reset
//   req0Valid/req0Reg/req0Data     : requester 0 (ALU/load) write request
//   req0Ready                      : requester 0 queue has room
//   req1Valid/req1Reg/req1Data     : requester 1 (multi-cycle unit) write request
//   req1Ready                      : requester 1 queue has room
//   regWrite/writeRegister/writeData : registered register-file write port
//   pendingMask                    : bit r set while a write to r is queued or staged
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req0Valid,
  input  logic [ADDR_W-1:0] req0Reg,
  input  logic [DATA_W-1:0] req0Data,
  output logic              req0Ready,
  input  logic              req1Valid,
  input  logic [ADDR_W-1:0] req1Reg,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req1Ready,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic [31:0]       pendingMask
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  logic [1:0]                 count0, count1;
  wb_req_t                    head0, head1;
  wb_req_t                    pushEntry0, pushEntry1;
  logic [1:0]                 entryValid0, entryValid1;
  logic [1:0][REG_ADDR_W-1:0] entryAddr0, entryAddr1;
  logic                       push0, push1;
  logic                       grant0, grant1;
  logic                       lastGrant;

  assign req0Ready = (count0 < DEPTH_CNT);
  assign req1Ready = (count1 < DEPTH_CNT);

  // Writes to register 0 complete the handshake but are dropped here.
  assign push0 = req0Valid && req0Ready && (req0Reg != '0);
  assign push1 = req1Valid && req1Ready && (req1Reg != '0);

  assign pushEntry0 = '{addr: req0Reg, data: req0Data};
  assign pushEntry1 = '{addr: req1Reg, data: req1Data};

  wb_queue uQueue0 (
    .clock      (clock),
    .rst        (rst),
    .push       (push0),
    .pushEntry  (pushEntry0),
    .pop        (grant0),
    .count      (count0),
    .headEntry  (head0),
    .entryValid (entryValid0),
    .entryAddr  (entryAddr0)
  );

  wb_queue uQueue1 (
    .clock      (clock),
    .rst        (rst),
    .push       (push1),
    .pushEntry  (pushEntry1),
    .pop        (grant1),
    .count      (count1),
    .headEntry  (head1),
    .entryValid (entryValid1),
    .entryAddr  (entryAddr1)
  );

  // Round robin: on a tie the requester that did not win last time goes.
  always_comb begin
    grant0 = (count0 != 2'd0) && ((count1 == 2'd0) || lastGrant);
    grant1 = (count1 != 2'd0) && ((count0 == 2'd0) || !lastGrant);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      lastGrant     <= 1'b1;
    end else begin
      regWrite <= grant0 || grant1;
      if (grant0) begin
        writeRegister <= head0.addr;
        writeData     <= head0.data;
        lastGrant     <= 1'b0;
      end else if (grant1) begin
        writeRegister <= head1.addr;
        writeData     <= head1.data;
        lastGrant     <= 1'b1;
      end
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < 2; i++) begin
      if (entryValid0[i]) pendingMask |= regOneHot(entryAddr0[i]);
      if (entryValid1[i]) pendingMask |= regOneHot(entryAddr1[i]);
    end
    if (regWrite) pendingMask |= regOneHot(writeRegister);
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clock;
  logic        rst;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0Reg, req1Reg;
  logic [31:0] req0Data, req1Data;
  logic        req0Ready, req1Ready;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] pendingMask;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] rfModel [32];
  int          vectors = 0;
  int          miscompares = 0;

  regfile_write_arbiter dut (
    .clock         (clock),
    .rst           (rst),
    .req0Valid     (req0Valid),
    .req0Reg       (req0Reg),
    .req0Data      (req0Data),
    .req0Ready     (req0Ready),
    .req1Valid     (req1Valid),
    .req1Reg       (req1Reg),
    .req1Data      (req1Data),
    .req1Ready     (req1Ready),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .pendingMask   (pendingMask)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    rst = 1'b1;
    #1;
    expQ.delete();
    @(negedge clock);
    rst = 1'b0;
    step();
  endtask

  // Present a request and hold it until an edge where ready was high.
  task automatic pushReq(input int which, input logic [4:0] r, input logic [31:0] d);
    logic rdy;
    int   n;
    n = 0;
    if (which == 0) begin
      req0Valid = 1'b1; req0Reg = r; req0Data = d;
    end else begin
      req1Valid = 1'b1; req1Reg = r; req1Data = d;
    end
    do begin
      rdy = (which == 0) ? req0Ready : req1Ready;
      step();
      n++;
    end while (!rdy && n < 20);
    if (!rdy) chk("acceptTimeout", 32'(which), 32'hFFFF_FFFF);
  endtask

  // Scoreboard monitor: every cycle with regWrite high is one commit.
  always @(negedge clock) begin
    if (regWrite) begin
      if (expQ.size() == 0) begin
        chk("unexpectedWrite", {27'd0, writeRegister}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("commitReg", {27'd0, writeRegister}, {27'd0, e.r});
        chk("commitData", writeData, e.d);
      end
      rfModel[writeRegister] = writeData;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req0Valid = 1'b0; req0Reg = '0; req0Data = '0;
    req1Valid = 1'b0; req1Reg = '0; req1Data = '0;
    for (int i = 0; i < 32; i++) rfModel[i] = '0;

    // Reset values
    @(negedge clock);
    chk("rstRegWrite", {31'd0, regWrite}, 32'd0);
    chk("rstMask", pendingMask, 32'd0);
    chk("rstReady0", {31'd0, req0Ready}, 32'd1);
    chk("rstReady1", {31'd0, req1Ready}, 32'd1);
    chk("rstWriteReg", {27'd0, writeRegister}, 32'd0);
    chk("rstWriteData", writeData, 32'd0);
    rst = 1'b0;
    step();

    // Single write
    req0Valid = 1'b1; req0Reg = 5'd5; req0Data = 32'hDEADBEEF;
    expQ.push_back('{r: 5'd5, d: 32'hDEADBEEF});
    step();
    req0Valid = 1'b0;
    @(negedge clock);
    chk("singleMaskT", pendingMask, 32'h0000_0020);
    chk("singleNoWriteYet", {31'd0, regWrite}, 32'd0);
    @(negedge clock);
    chk("singleRegWrite", {31'd0, regWrite}, 32'd1);
    chk("singleWriteReg", {27'd0, writeRegister}, 32'd5);
    chk("singleMaskT1", pendingMask, 32'h0000_0020);
    @(negedge clock);
    chk("singleIdle", {31'd0, regWrite}, 32'd0);
    chk("singleMaskClear", pendingMask, 32'd0);

    // Contention / full queue
    doReset();
    for (int i = 0; i < 4; i++) begin
      expQ.push_back('{r: 5'(1 + i), d: 32'h100 + i});
      expQ.push_back('{r: 5'(11 + i), d: 32'h200 + i});
    end
    fork
      begin
        for (int i = 0; i < 4; i++) pushReq(0, 5'(1 + i), 32'h100 + i);
        req0Valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) pushReq(1, 5'(11 + i), 32'h200 + i);
        req1Valid = 1'b0;
      end
      begin
        @(negedge clock);
        chk("contReady0Pre", {31'd0, req0Ready}, 32'd1);
        chk("contReady1Pre", {31'd0, req1Ready}, 32'd1);
        @(negedge clock);
        chk("contMaskE1", pendingMask, 32'h0000_0802);
        chk("contRegWriteE1", {31'd0, regWrite}, 32'd0);
        @(negedge clock);
        chk("contReady1Full", {31'd0, req1Ready}, 32'd0);
        chk("contReady0E2", {31'd0, req0Ready}, 32'd1);
        chk("contMaskE2", pendingMask, 32'h0000_1806);
        @(negedge clock);
        chk("contReady1Freed", {31'd0, req1Ready}, 32'd1);
        chk("contReady0Full", {31'd0, req0Ready}, 32'd0);
        chk("contMaskE3", pendingMask, 32'h0000_180C);
      end
    join
    n = 0;
    while (expQ.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("contDrained", 32'(expQ.size()), 32'd0);
    step();

    // Register 0 is discarded; req1 next cycle goes straight through
    req0Valid = 1'b1; req0Reg = 5'd0; req0Data = 32'h1234;
    step();
    req0Valid = 1'b0;
    req1Valid = 1'b1; req1Reg = 5'd9; req1Data = 32'h55;
    expQ.push_back('{r: 5'd9, d: 32'h55});
    @(negedge clock);
    chk("r0Mask", pendingMask, 32'd0);
    chk("r0NoWrite", {31'd0, regWrite}, 32'd0);
    chk("r0Ready0", {31'd0, req0Ready}, 32'd1);
    step();
    req1Valid = 1'b0;
    @(negedge clock);
    chk("r0StillNoWrite", {31'd0, regWrite}, 32'd0);
    chk("r0Mask9", pendingMask, 32'h0000_0200);
    @(negedge clock);
    chk("r0Req1Write", {31'd0, regWrite}, 32'd1);
    chk("r0Req1Reg", {27'd0, writeRegister}, 32'd9);
    step();

    // Same destination from both requesters
    req0Valid = 1'b1; req0Reg = 5'd7; req0Data = 32'd1;
    expQ.push_back('{r: 5'd7, d: 32'd1});
    step();
    req0Valid = 1'b0;
    req1Valid = 1'b1; req1Reg = 5'd7; req1Data = 32'd2;
    expQ.push_back('{r: 5'd7, d: 32'd2});
    @(negedge clock);
    chk("sameMaskT", pendingMask, 32'h0000_0080);
    step();
    req1Valid = 1'b0;
    @(negedge clock);
    chk("sameFirstData", writeData, 32'd1);
    chk("sameMaskT1", pendingMask, 32'h0000_0080);
    @(negedge clock);
    chk("sameSecondData", writeData, 32'd2);
    chk("sameMaskT2", pendingMask, 32'h0000_0080);
    @(negedge clock);
    chk("sameMaskClear", pendingMask, 32'd0);
    chk("sameFinalValue", rfModel[7], 32'd2);
    step();

    // Reset in the middle of a burst
    req0Valid = 1'b1; req0Reg = 5'd3; req0Data = 32'h33;
    expQ.push_back('{r: 5'd3, d: 32'h33});
    step();
    req0Reg = 5'd4; req0Data = 32'h44;
    step();
    req0Valid = 1'b0;
    @(negedge clock);
    chk("midMaskBefore", pendingMask, 32'h0000_0018);
    #2;
    rst = 1'b1;
    #1;
    chk("midRegWrite", {31'd0, regWrite}, 32'd0);
    chk("midMask", pendingMask, 32'd0);
    chk("midReady0", {31'd0, req0Ready}, 32'd1);
    chk("midWriteReg", {27'd0, writeRegister}, 32'd0);
    chk("midWriteData", writeData, 32'd0);
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    chk("finalQueueEmpty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
